// File: rtl/hyper_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hyper_pkg                                                    |
// | Description : Shared definitions for the HyperBus responder: FSM state    |
// |               encodings, command/address field positions, register        |
// |               addresses and the register-space read decoder.              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package hyper_pkg;

    // Responder FSM states.
    typedef logic [2:0] state_t;
    localparam state_t c_IDLE  = 3'd0;
    localparam state_t c_CA    = 3'd1;
    localparam state_t c_LAT   = 3'd2;
    localparam state_t c_REGW  = 3'd3;
    localparam state_t c_WDATA = 3'd4;
    localparam state_t c_RDATA = 3'd5;
    localparam state_t c_DONE  = 3'd6;

    // Command/address word layout (48 bits, MSB byte first on the bus).
    localparam int c_CA_BYTES  = 6;
    localparam int c_CA_RW     = 47;  // 1 = read
    localparam int c_CA_AS     = 46;  // 1 = register space
    localparam int c_CA_BURST  = 45;  // 1 = linear, 0 = wrapped
    localparam int c_CA_ROW_HI = 44;
    localparam int c_CA_ROW_LO = 16;
    localparam int c_CA_COL_HI = 2;

    // Register-space word addresses (compared against the untruncated address).
    localparam logic [31:0] c_ID0_ADDR = 32'h0000_0000;
    localparam logic [31:0] c_CR0_ADDR = 32'h0000_0800;

    // Register-space read decode; unmapped addresses read as zero.
    function automatic logic [15:0] reg_read(input logic [31:0] addr,
                                             input logic [15:0] id0,
                                             input logic [15:0] cr0);
        logic [15:0] v;
        v = 16'h0000;
        if (addr == c_ID0_ADDR) begin
            v = id0;
        end else if (addr == c_CR0_ADDR) begin
            v = cr0;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hyper_target_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hyper_target_mem                                             |
// | Description : DEPTH x 16-bit word store, one byte-enabled synchronous     |
// |               write port and one combinational read port. No reset.      |
// | Ports       : clk      - clock                                            |
// |               i_we     - write strobe                                      |
// |               i_be     - byte enables, [1] = high byte, [0] = low byte     |
// |               i_waddr  - write word address                                |
// |               i_wdata  - write data                                        |
// |               i_raddr  - read word address                                 |
// |               o_rdata  - read data (combinational)                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module hyper_target_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [1:0]    i_be,
    input  logic [AW-1:0] i_waddr,
    input  logic [15:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [15:0]   o_rdata
);

    // One independent array per byte lane so each lane has a single writer.
    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [7:0] r_lane [DEPTH];

        always_ff @(posedge clk) begin
            if (i_we && i_be[g]) begin
                r_lane[i_waddr] <= i_wdata[8*g +: 8];
            end
        end

        assign o_rdata[8*g +: 8] = r_lane[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/hyper_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hyper_target                                                 |
// | Description : Synthesizable HyperBus responder (memory-device end of the  |
// |               link). Decodes the 6-byte command/address, applies a fixed  |
// |               2x latency, and serves memory and register reads/writes.    |
// | Ports       : clk            - system clock (same clock that makes CK)    |
// |               reset_l        - asynchronous active-low reset              |
// |               dram_ck        - HyperBus CK from the controller            |
// |               dram_cs_l      - chip select, active low                    |
// |               dram_rst_l     - device reset, active low, sampled on clk   |
// |               dram_dq_in     - DQ from the controller                     |
// |               dram_dq_out    - DQ driven by this target                   |
// |               dram_dq_oe_l   - DQ output enable, active low               |
// |               dram_rwds_in   - RWDS from controller (write byte mask)     |
// |               dram_rwds_out  - RWDS driven by this target                 |
// |               dram_rwds_oe_l - RWDS output enable, active low             |
// |               cr0            - current CR0 contents                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module hyper_target
    import hyper_pkg::*;
#(
    parameter int          DEPTH     = 1024,      // power of two, >= 16
    parameter int          LAT_EDGES = 24,        // >= 2
    parameter logic [15:0] ID0_VAL   = 16'h0C81,
    parameter logic [15:0] CR0_RST   = 16'h8F1F
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        dram_ck,
    input  logic        dram_cs_l,
    input  logic        dram_rst_l,
    input  logic [7:0]  dram_dq_in,
    output logic [7:0]  dram_dq_out,
    output logic        dram_dq_oe_l,
    input  logic        dram_rwds_in,
    output logic        dram_rwds_out,
    output logic        dram_rwds_oe_l,
    output logic [15:0] cr0
);

    localparam int c_AW = $clog2(DEPTH);
    // The first data edge is LAT_EDGES edges after the last CA edge, so the
    // FSM leaves LAT on the (LAT_EDGES-1)th latency edge; r_cnt counts from 0.
    localparam logic [7:0] c_LAT_TURN = 8'(LAT_EDGES - 2);
    localparam logic [7:0] c_CA_LAST  = 8'(c_CA_BYTES - 1);

    state_t      r_state;
    logic        r_ck_q;
    logic [7:0]  r_cnt;
    logic [39:0] r_ca;         // low 40 bits of the CA shift register
    logic        r_rd;
    logic        r_rs;
    logic        r_lin;
    logic [31:0] r_addr;       // untruncated word address
    logic        r_half;       // 0 = next edge is high byte, 1 = low byte
    logic [7:0]  r_wbuf;
    logic        r_wmask_hi;
    logic [7:0]  r_dq_out;
    logic        r_dq_oe_l;
    logic        r_rwds_out;
    logic        r_rwds_oe_l;
    logic [15:0] r_cr0;

    logic        w_bus_edge;
    logic [47:0] w_ca_nxt;
    logic [31:0] w_ca_addr;
    logic [31:0] w_addr_adv;
    logic [15:0] w_mem_rdata;
    logic [15:0] w_rd_word;
    logic        w_mem_we;
    logic [1:0]  w_mem_be;

    // CS high suppresses edges, so a cs rise always wins over a coincident edge.
    assign w_bus_edge = !dram_cs_l && (dram_ck != r_ck_q);
    assign w_ca_nxt   = {r_ca, dram_dq_in};
    assign w_ca_addr  = {w_ca_nxt[c_CA_ROW_HI:c_CA_ROW_LO], w_ca_nxt[c_CA_COL_HI:0]};

    // Linear bursts wrap modulo DEPTH; wrapped bursts stay in a 16-word group.
    assign w_addr_adv = r_lin ? {r_addr[31:c_AW], r_addr[c_AW-1:0] + 1'b1}
                              : {r_addr[31:4], r_addr[3:0] + 4'd1};

    assign w_rd_word  = r_rs ? reg_read(r_addr, ID0_VAL, r_cr0) : w_mem_rdata;

    // Commit happens on the low-byte edge; a word cut short by cs never writes.
    assign w_mem_we   = w_bus_edge && (r_state == c_WDATA) && r_half;
    assign w_mem_be   = {~r_wmask_hi, ~dram_rwds_in};

    hyper_target_mem #(
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_be    (w_mem_be),
        .i_waddr (r_addr[c_AW-1:0]),
        .i_wdata ({r_wbuf, dram_dq_in}),
        .i_raddr (r_addr[c_AW-1:0]),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state     <= c_IDLE;
            r_ck_q      <= 1'b0;
            r_cnt       <= 8'd0;
            r_ca        <= 40'd0;
            r_rd        <= 1'b0;
            r_rs        <= 1'b0;
            r_lin       <= 1'b0;
            r_addr      <= 32'd0;
            r_half      <= 1'b0;
            r_wbuf      <= 8'd0;
            r_wmask_hi  <= 1'b0;
            r_dq_out    <= 8'd0;
            r_dq_oe_l   <= 1'b1;
            r_rwds_out  <= 1'b0;
            r_rwds_oe_l <= 1'b1;
            r_cr0       <= CR0_RST;
        end else begin
            r_ck_q <= dram_ck;
            if (!dram_rst_l) begin
                r_state     <= c_IDLE;
                r_dq_oe_l   <= 1'b1;
                r_rwds_oe_l <= 1'b1;
                r_half      <= 1'b0;
                r_cr0       <= CR0_RST;
            end else if (dram_cs_l && (r_state != c_IDLE)) begin
                r_state     <= c_IDLE;
                r_dq_oe_l   <= 1'b1;
                r_rwds_oe_l <= 1'b1;
                r_half      <= 1'b0;
            end else if (w_bus_edge) begin
                case (r_state)
                    c_IDLE: begin
                        // First edge after cs falls carries CA byte 0.
                        r_ca        <= w_ca_nxt[39:0];
                        r_cnt       <= 8'd1;
                        r_state     <= c_CA;
                        r_rwds_oe_l <= 1'b0;
                        r_rwds_out  <= 1'b1;   // advertise 2x latency
                    end
                    c_CA: begin
                        r_ca  <= w_ca_nxt[39:0];
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == c_CA_LAST) begin
                            r_rd        <= w_ca_nxt[c_CA_RW];
                            r_rs        <= w_ca_nxt[c_CA_AS];
                            r_lin       <= w_ca_nxt[c_CA_BURST];
                            r_addr      <= w_ca_addr;
                            r_cnt       <= 8'd0;
                            r_half      <= 1'b0;
                            r_rwds_oe_l <= 1'b1;
                            r_rwds_out  <= 1'b0;
                            if (!w_ca_nxt[c_CA_RW] && w_ca_nxt[c_CA_AS]) begin
                                r_state <= c_REGW;
                            end else begin
                                r_state <= c_LAT;
                            end
                        end
                    end
                    c_LAT: begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == c_LAT_TURN) begin
                            if (r_rd) begin
                                // Turn the bus around one edge ahead of data.
                                r_state     <= c_RDATA;
                                r_dq_oe_l   <= 1'b0;
                                r_rwds_oe_l <= 1'b0;
                                r_rwds_out  <= 1'b0;
                            end else begin
                                r_state <= c_WDATA;
                            end
                        end
                    end
                    c_REGW: begin
                        if (!r_half) begin
                            r_wbuf <= dram_dq_in;
                            r_half <= 1'b1;
                        end else begin
                            if (r_addr == c_CR0_ADDR) begin
                                r_cr0 <= {r_wbuf, dram_dq_in};
                            end
                            r_half  <= 1'b0;
                            r_state <= c_DONE;
                        end
                    end
                    c_WDATA: begin
                        if (!r_half) begin
                            r_wbuf     <= dram_dq_in;
                            r_wmask_hi <= dram_rwds_in;
                            r_half     <= 1'b1;
                        end else begin
                            r_half <= 1'b0;
                            r_addr <= w_addr_adv;
                        end
                    end
                    c_RDATA: begin
                        if (!r_half) begin
                            r_dq_out   <= w_rd_word[15:8];
                            r_rwds_out <= 1'b1;
                            r_half     <= 1'b1;
                        end else begin
                            r_dq_out   <= w_rd_word[7:0];
                            r_rwds_out <= 1'b0;
                            r_half     <= 1'b0;
                            r_addr     <= w_addr_adv;
                        end
                    end
                    c_DONE: begin
                        r_state <= c_DONE;   // hold until cs rises
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

    assign dram_dq_out    = r_dq_out;
    assign dram_dq_oe_l   = r_dq_oe_l;
    assign dram_rwds_out  = r_rwds_out;
    assign dram_rwds_oe_l = r_rwds_oe_l;
    assign cr0            = r_cr0;

endmodule
`default_nettype wire

// File: tb/tb_hyper_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hyper_target                                              |
// | Description : Self-checking bench for hyper_target. A word model and CR0  |
// |               model predict read data, which is queued when a read is    |
// |               issued and compared byte by byte as the target drives it.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_hyper_target;

    localparam int DEPTH     = 1024;   // model addressing below assumes 10 bits
    localparam int LAT_EDGES = 24;

    logic        clk = 1'b0;
    logic        reset_l;
    logic        dram_ck;
    logic        dram_cs_l;
    logic        dram_rst_l;
    logic [7:0]  dram_dq_in;
    logic [7:0]  dram_dq_out;
    logic        dram_dq_oe_l;
    logic        dram_rwds_in;
    logic        dram_rwds_out;
    logic        dram_rwds_oe_l;
    logic [15:0] cr0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          gap      = 0;       // idle clk cycles inserted after each edge
    logic [15:0] m_mem [DEPTH];
    logic [15:0] m_cr0;
    logic [8:0]  sb [$];             // {rwds, byte} expected on read edges

    hyper_target #(
        .DEPTH     (DEPTH),
        .LAT_EDGES (LAT_EDGES),
        .ID0_VAL   (16'h0C81),
        .CR0_RST   (16'h8F1F)
    ) dut (
        .clk            (clk),
        .reset_l        (reset_l),
        .dram_ck        (dram_ck),
        .dram_cs_l      (dram_cs_l),
        .dram_rst_l     (dram_rst_l),
        .dram_dq_in     (dram_dq_in),
        .dram_dq_out    (dram_dq_out),
        .dram_dq_oe_l   (dram_dq_oe_l),
        .dram_rwds_in   (dram_rwds_in),
        .dram_rwds_out  (dram_rwds_out),
        .dram_rwds_oe_l (dram_rwds_oe_l),
        .cr0            (cr0)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] mk_ca(input logic rd, input logic rs, input logic lin,
                                          input logic [31:0] a);
        logic [47:0] c;
        c        = '0;
        c[47]    = rd;
        c[46]    = rs;
        c[45]    = lin;
        c[44:16] = a[31:3];
        c[2:0]   = a[2:0];
        return c;
    endfunction

    function automatic logic [31:0] adv(input logic [31:0] a, input logic lin);
        return lin ? {a[31:10], a[9:0] + 10'd1} : {a[31:4], a[3:0] + 4'd1};
    endfunction

    function automatic logic [15:0] m_read(input logic rs, input logic [31:0] a);
        if (!rs) return m_mem[a[9:0]];
        if (a == 32'h0) return 16'h0C81;
        if (a == 32'h800) return m_cr0;
        return 16'h0000;
    endfunction

    // One CK transition carrying a byte; outputs are sampled 1 time unit
    // after the clk edge that sees it.
    task automatic bus_edge(input logic [7:0] d, input logic m);
        dram_dq_in   = d;
        dram_rwds_in = m;
        dram_ck      = ~dram_ck;
        @(posedge clk); #1;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic ca_phase(input logic [47:0] ca);
        dram_cs_l = 1'b0;
        @(posedge clk); #1;
        for (int b = 0; b < 6; b++) begin
            bus_edge(ca[47-8*b -: 8], 1'b0);
            if (b == 0) begin
                check_val("ca_rwds_oe", dram_rwds_oe_l, 0);
                check_val("ca_rwds", dram_rwds_out, 1);
            end
        end
        check_val("ca_release", dram_rwds_oe_l, 1);
    endtask

    task automatic lat_phase(input logic rd);
        for (int i = 0; i < LAT_EDGES - 1; i++) begin
            if (rd && i == LAT_EDGES - 2) check_val("oe_early", dram_dq_oe_l, 1);
            bus_edge(8'h00, 1'b0);
        end
        if (rd) begin
            check_val("oe_turn", dram_dq_oe_l, 0);
            check_val("rwds_oe_turn", dram_rwds_oe_l, 0);
            check_val("rwds_pre_data", dram_rwds_out, 0);
        end else begin
            check_val("wr_oe", dram_dq_oe_l, 1);
        end
    endtask

    task automatic end_txn();
        dram_cs_l = 1'b1;
        @(posedge clk); #1;
        check_val("end_dq_oe", dram_dq_oe_l, 1);
        check_val("end_rwds_oe", dram_rwds_oe_l, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic lin, input int n,
                            input logic [15:0] d0, input logic [1:0] mask);
        logic [31:0] p;
        logic [15:0] w;
        ca_phase(mk_ca(1'b0, 1'b0, lin, a));
        lat_phase(1'b0);
        p = a;
        for (int i = 0; i < n; i++) begin
            w = d0 + 16'(i) * 16'h0101;
            bus_edge(w[15:8], mask[1]);
            bus_edge(w[7:0], mask[0]);
            if (!mask[1]) m_mem[p[9:0]][15:8] = w[15:8];
            if (!mask[0]) m_mem[p[9:0]][7:0]  = w[7:0];
            p = adv(p, lin);
        end
        end_txn();
    endtask

    task automatic do_read(input logic rs, input logic lin, input logic [31:0] a, input int n);
        logic [31:0] p;
        logic [15:0] w;
        logic [8:0]  e;
        p = a;
        for (int i = 0; i < n; i++) begin
            w = m_read(rs, p);
            sb.push_back({1'b1, w[15:8]});
            sb.push_back({1'b0, w[7:0]});
            p = adv(p, lin);
        end
        ca_phase(mk_ca(1'b1, rs, lin, a));
        lat_phase(1'b1);
        for (int k = 0; k < 2 * n; k++) begin
            bus_edge(8'h00, 1'b0);
            e = sb.pop_front();
            check_val($sformatf("rd_%0h_%0d", a, k), {23'd0, dram_rwds_out, dram_dq_out}, {23'd0, e});
        end
        end_txn();
    endtask

    task automatic do_regwrite(input logic [31:0] a, input logic [15:0] d);
        ca_phase(mk_ca(1'b0, 1'b1, 1'b1, a));
        bus_edge(d[15:8], 1'b0);
        bus_edge(d[7:0], 1'b0);
        if (a == 32'h800) m_cr0 = d;
        check_val($sformatf("cr0_wr_%0h", a), cr0, m_cr0);
        end_txn();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_l      = 1'b0;
        dram_ck      = 1'b0;
        dram_cs_l    = 1'b1;
        dram_rst_l   = 1'b1;
        dram_dq_in   = 8'h00;
        dram_rwds_in = 1'b0;
        m_cr0        = 16'h8F1F;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_dq", dram_dq_out, 0);
        check_val("rst_rwds", dram_rwds_out, 0);
        check_val("rst_dq_oe", dram_dq_oe_l, 1);
        check_val("rst_rwds_oe", dram_rwds_oe_l, 1);
        check_val("rst_cr0", cr0, 16'h8F1F);
        reset_l = 1'b1;
        @(posedge clk); #1;

        // Linear write/read at 'h10, write with idle cycles between CK edges.
        gap = 1;
        do_write(32'h10, 1'b1, 1, 16'hA55A, 2'b00);
        gap = 0;
        do_read(1'b0, 1'b1, 32'h10, 1);

        // Masked write: low byte keeps its old 8'hFF.
        do_write(32'h20, 1'b1, 1, 16'hFFFF, 2'b00);
        do_write(32'h20, 1'b1, 1, 16'h1234, 2'b01);
        do_read(1'b0, 1'b1, 32'h20, 1);

        // Register space.
        do_read(1'b1, 1'b1, 32'h0, 1);
        do_regwrite(32'h800, 16'h8F17);
        do_regwrite(32'h001, 16'h1234);
        do_read(1'b1, 1'b1, 32'h800, 1);

        // Wrapped burst across the 16-word group and linear wrap at DEPTH.
        do_write(32'h11, 1'b1, 15, 16'h1100, 2'b00);
        do_read(1'b0, 1'b0, 32'h1E, 17);
        do_write(32'h3FF, 1'b1, 2, 16'hC0DE, 2'b00);
        do_read(1'b0, 1'b1, 32'h3FF, 2);

        // cs rises (with a coincident CK edge) after only the high byte.
        do_write(32'h40, 1'b1, 1, 16'hBEEF, 2'b00);
        ca_phase(mk_ca(1'b0, 1'b0, 1'b1, 32'h40));
        lat_phase(1'b0);
        bus_edge(8'h11, 1'b0);
        dram_dq_in = 8'h22;
        dram_ck    = ~dram_ck;
        dram_cs_l  = 1'b1;
        @(posedge clk); #1;
        check_val("abort_dq_oe", dram_dq_oe_l, 1);
        check_val("abort_rwds_oe", dram_rwds_oe_l, 1);
        @(posedge clk); #1;
        do_read(1'b0, 1'b1, 32'h40, 1);

        // Asynchronous reset in the middle of a read.
        ca_phase(mk_ca(1'b1, 1'b0, 1'b1, 32'h10));
        lat_phase(1'b1);
        bus_edge(8'h00, 1'b0);
        check_val("rst_mid_byte", {dram_rwds_out, dram_dq_out}, {1'b1, m_mem[10'h10][15:8]});
        #2 reset_l = 1'b0;
        #1;
        m_cr0 = 16'h8F1F;
        check_val("arst_dq_oe", dram_dq_oe_l, 1);
        check_val("arst_rwds_oe", dram_rwds_oe_l, 1);
        check_val("arst_cr0", cr0, m_cr0);
        dram_cs_l = 1'b1;
        @(posedge clk); #1;
        reset_l = 1'b1;
        @(posedge clk); #1;

        // Device reset pin reloads CR0.
        do_regwrite(32'h800, 16'h0F10);
        dram_rst_l = 1'b0;
        @(posedge clk); #1;
        m_cr0 = 16'h8F1F;
        check_val("drst_cr0", cr0, m_cr0);
        dram_rst_l = 1'b1;
        @(posedge clk); #1;

        // Memory survives both resets.
        do_read(1'b0, 1'b1, 32'h20, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
